qsys_d7seg_scan: RTL and testbench

Multiplexed scan driver for a 4-digit common-anode 7-segment display. It consumes the 16-bit hex value written by the CPU into the display PIO register, with one nibble per digit. It time-multiplexes the four digits with a programmable slot length and anti-ghosting dead time, and decodes each nibble to segment patterns. New values are latched only at frame boundaries, so the display never tears. It sits in the top level between the PIO output port and the board display pins.

---
 rtl/qsys_d7seg_scan_if.sv | 22 ++
 rtl/qsys_d7seg_scan.sv | 128 ++++++++++++
 tb/tb_qsys_d7seg_scan.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/qsys_d7seg_scan_if.sv
// Signal bundle between the display PIO register and the 7-segment scan driver.
// The master drives the display request and the slave returns the pin-level drive.
interface qsys_d7seg_scan_if;
  logic        enable;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic        lz_blank;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  dig;
  logic        frame_tick;

  modport master (
    output enable, data_in, dp_in, lz_blank,
    input  seg, dp, dig, frame_tick
  );

  modport slave (
    input  enable, data_in, dp_in, lz_blank,
    output seg, dp, dig, frame_tick
  );
endinterface

// File: rtl/qsys_d7seg_scan.sv
// Four-digit common-anode 7-segment scan driver: frame-synchronous shadow of the
// hex value, dead-time blanking between digits, leading-zero suppression.
module qsys_d7seg_scan #(
  parameter int unsigned SCAN_DIV = 12500,
  parameter int unsigned DEAD     = 16
) (
  input logic              clk,
  input logic              reset_n,
  qsys_d7seg_scan_if.slave bus
);

  localparam int unsigned   CW       = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEAD_END = CW'(DEAD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   data_q, data_d;
  logic [3:0]    dpin_q, dpin_d;
  logic          lz_q, lz_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [3:0]    dig_q, dig_d;
  logic          tick_q, tick_d;

  logic          wrap, frame_end, in_dead, blank;
  logic [3:0]    nibble;
  logic [6:0]    glyph;

  // Active-high gfedcba pattern for one hex digit.
  function automatic logic [6:0] hex_glyph(input logic [3:0] n);
    case (n)
      4'h0: hex_glyph = 7'h3F;  4'h1: hex_glyph = 7'h06;
      4'h2: hex_glyph = 7'h5B;  4'h3: hex_glyph = 7'h4F;
      4'h4: hex_glyph = 7'h66;  4'h5: hex_glyph = 7'h6D;
      4'h6: hex_glyph = 7'h7D;  4'h7: hex_glyph = 7'h07;
      4'h8: hex_glyph = 7'h7F;  4'h9: hex_glyph = 7'h6F;
      4'hA: hex_glyph = 7'h77;  4'hB: hex_glyph = 7'h7C;
      4'hC: hex_glyph = 7'h39;  4'hD: hex_glyph = 7'h5E;
      4'hE: hex_glyph = 7'h79;  default: hex_glyph = 7'h71;
    endcase
  endfunction

  always_comb begin
    wrap      = (cnt_q == CNT_LAST);
    frame_end = wrap && (idx_q == 2'd3);
    in_dead   = (cnt_q < DEAD_END);
    nibble    = data_q[{idx_q, 2'b00} +: 4];
    // NOTE: every always_comb output gets a default up front so no path can infer a latch.
    blank = 1'b0;
    case (idx_q)
      2'd3:    blank = lz_q && (data_q[15:12] == 4'h0);
      2'd2:    blank = lz_q && (data_q[15:8]  == 8'h00);
      2'd1:    blank = lz_q && (data_q[15:4]  == 12'h000);
      default: blank = 1'b0;
    endcase
    glyph = blank ? 7'h7F : ~hex_glyph(nibble);
  end

  // Scan position and frame shadow; disable parks at digit 0 and tracks the input live.
  always_comb begin
    cnt_d  = '0;
    idx_d  = 2'd0;
    data_d = data_q;
    dpin_d = dpin_q;
    lz_d   = lz_q;
    if (bus.enable) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
      idx_d = wrap ? idx_q + 2'd1 : idx_q;
    end
    if (!bus.enable || frame_end) begin
      data_d = bus.data_in;
      dpin_d = bus.dp_in;
      lz_d   = bus.lz_blank;
    end
  end

  // seg/dp only move inside the dead window, so they are frozen while a digit is lit.
  always_comb begin
    seg_d  = seg_q;
    dp_d   = dp_q;
    dig_d  = 4'hF;
    tick_d = 1'b0;
    if (!bus.enable) begin
      seg_d = 7'h7F;
      dp_d  = 1'b1;
    end else begin
      tick_d = frame_end;
      if (in_dead) begin
        seg_d = glyph;
        dp_d  = ~dpin_q[idx_q];
      end else begin
        dig_d = ~(4'b0001 << idx_q);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      idx_q  <= 2'd0;
      data_q <= 16'h0000;
      dpin_q <= 4'h0;
      lz_q   <= 1'b0;
      seg_q  <= 7'h7F;
      dp_q   <= 1'b1;
      dig_q  <= 4'hF;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      data_q <= data_d;
      dpin_q <= dpin_d;
      lz_q   <= lz_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
      dig_q  <= dig_d;
      tick_q <= tick_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.dig        = dig_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_qsys_d7seg_scan.sv
// Scoreboard bench for qsys_d7seg_scan: per-frame expected digits are queued at each
// frame_tick and a monitor pops one entry every time a digit lights.
module tb_qsys_d7seg_scan;

  localparam int SCAN_DIV = 8;
  localparam int DEAD     = 2;
  localparam int BUDGET   = 4 * SCAN_DIV + 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  qsys_d7seg_scan_if bus ();

  qsys_d7seg_scan #(.SCAN_DIV(SCAN_DIV), .DEAD(DEAD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [1:0] digit;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  // segs/dps are packed {digit3, digit2, digit1, digit0}, already active-low.
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dpr;
    logic        lz;
    logic [27:0] segs;
    logic [3:0]  dps;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[9];
  int   n_vec  = 0;
  int   n_miss = 0;
  logic timing_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.data_in  = v.data;
    bus.dp_in    = v.dpr;
    bus.lz_blank = v.lz;
  endtask

  task automatic push_frame(input vec_t v);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.digit = 2'(k);
      e.seg   = v.segs[k*7 +: 7];
      e.dp    = v.dps[k];
      sb_q.push_back(e);
    end
  endtask

  task automatic wait_tick(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.frame_tick && n < budget);
    check("wait_tick", bus.frame_tick, 1);
  endtask

  task automatic wait_digit(input int k, input int budget);
    logic [3:0] want;
    int n = 0;
    want = ~(4'b0001 << k);
    do begin
      @(negedge clk);
      n++;
    end while (bus.dig != want && n < budget);
    check("wait_digit", bus.dig, want);
  endtask

  task automatic release_reset(input string name);
    int n = 0;
    @(negedge clk);
    reset_n = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (bus.dig == 4'hF && n < 20);
    check(name, n, DEAD + 1);
    check({name, "_dig"}, bus.dig, 4'b1110);
  endtask

  // Monitor: scoreboard pops at every lit-digit start; scan timing rules while timing_on.
  initial begin
    logic [3:0] prev_dig = 4'hF;
    logic [6:0] prev_seg = 7'h7F;
    logic       prev_dp  = 1'b1;
    logic [3:0] exp_dig;
    logic       lit, prev_lit;
    logic       run_valid = 1'b0, gap_valid = 1'b0, ft_valid = 1'b0;
    int         run_len = 0, gap_len = 0, cyc = 0, last_ft = 0;
    exp_t       e;
    forever begin
      @(negedge clk);
      cyc++;
      lit      = (bus.dig != 4'hF);
      prev_lit = (prev_dig != 4'hF);
      if (reset_n && lit && !prev_lit && sb_q.size() > 0) begin
        e = sb_q.pop_front();
        exp_dig = ~(4'b0001 << e.digit);
        check("sb_dig", bus.dig, exp_dig);
        check("sb_seg", bus.seg, e.seg);
        check("sb_dp", bus.dp, e.dp);
      end
      if (!timing_on) begin
        run_valid = 1'b0;
        gap_valid = 1'b0;
        ft_valid  = 1'b0;
      end else begin
        check("dig_onehot", ($countones(~bus.dig) <= 1), 1);
        if (lit && !prev_lit) begin
          if (gap_valid) check("dead_gap", gap_len, DEAD);
          run_valid = 1'b1;
          run_len   = 1;
        end else if (lit && prev_lit) begin
          run_len++;
          check("dig_steady", bus.dig, prev_dig);
          check("seg_steady", bus.seg, prev_seg);
          check("dp_steady", bus.dp, prev_dp);
        end else if (!lit && prev_lit) begin
          if (run_valid) check("lit_run", run_len, SCAN_DIV - DEAD);
          gap_valid = 1'b1;
          gap_len   = 1;
        end else begin
          gap_len++;
        end
        if (bus.frame_tick) begin
          if (ft_valid) check("tick_period", cyc - last_ft, 4 * SCAN_DIV);
          ft_valid = 1'b1;
          last_ft  = cyc;
        end
      end
      prev_dig = bus.dig;
      prev_seg = bus.seg;
      prev_dp  = bus.dp;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   lit_n, ft_n;
    vecs[0] = '{16'h1234, 4'b0001, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1110};
    vecs[1] = '{16'hABCD, 4'b0000, 1'b0, {7'h08, 7'h03, 7'h46, 7'h21}, 4'b1111};
    vecs[2] = '{16'h3210, 4'b0000, 1'b0, {7'h30, 7'h24, 7'h79, 7'h40}, 4'b1111};
    vecs[3] = '{16'h7654, 4'b1010, 1'b0, {7'h78, 7'h02, 7'h12, 7'h19}, 4'b0101};
    vecs[4] = '{16'hBA98, 4'b0100, 1'b0, {7'h03, 7'h08, 7'h10, 7'h00}, 4'b1011};
    vecs[5] = '{16'hFEDC, 4'b1111, 1'b0, {7'h0E, 7'h06, 7'h21, 7'h46}, 4'b0000};
    vecs[6] = '{16'h0050, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
    vecs[7] = '{16'h0000, 4'b0010, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1101};
    vecs[8] = '{16'h0000, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};

    reset_n    = 1'b0;
    bus.enable = 1'b1;
    drive(vecs[0]);
    repeat (3) @(negedge clk);
    check("rst_dig", bus.dig, 4'hF);
    check("rst_seg", bus.seg, 7'h7F);
    check("rst_dp", bus.dp, 1);
    check("rst_tick", bus.frame_tick, 0);
    release_reset("por_latency");

    // Reset mid-scan with digit 2 lit: outputs clear without waiting for a clock.
    wait_digit(2, BUDGET);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_dig", bus.dig, 4'hF);
    check("async_rst_seg", bus.seg, 7'h7F);
    check("async_rst_dp", bus.dp, 1);
    check("async_rst_tick", bus.frame_tick, 0);
    push_frame(vecs[8]);
    repeat (2) @(negedge clk);
    check("rst_hold_dig", bus.dig, 4'hF);
    release_reset("rst_latency");

    // Each vector is loaded at a frame_tick; the next one is applied during digit 1's slot.
    for (int i = 0; i < 9; i++) begin
      wait_tick(BUDGET);
      push_frame(vecs[i]);
      if (i < 8) begin
        wait_digit(1, BUDGET);
        drive(vecs[i + 1]);
      end
    end

    // Enable drop during digit 2's slot; a new value is captured while disabled.
    wait_tick(BUDGET);
    wait_digit(2, BUDGET);
    bus.enable = 1'b0;
    v = '{16'h5678, 4'b0000, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}, 4'b1111};
    drive(v);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("dis_dig", bus.dig, 4'hF);
      check("dis_seg", bus.seg, 7'h7F);
      check("dis_dp", bus.dp, 1);
      check("dis_tick", bus.frame_tick, 0);
    end
    push_frame(v);
    bus.enable = 1'b1;
    lit_n = 0;
    ft_n  = 0;
    for (int n = 1; n <= BUDGET && ft_n == 0; n++) begin
      @(negedge clk);
      if (lit_n == 0 && bus.dig != 4'hF) lit_n = n;
      if (bus.frame_tick) ft_n = n;
    end
    check("reen_lit", lit_n, DEAD + 1);
    check("reen_tick", ft_n, 4 * SCAN_DIV);

    // Ten frames of free-running scan under the timing monitor.
    timing_on = 1'b1;
    for (int f = 0; f < 10; f++) wait_tick(BUDGET);
    timing_on = 1'b0;

    @(negedge clk);
    check("sb_drain", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
